cbfp_scale_ctrl: RTL and testbench

CBFP_SCALE_CTRL -- requirements
Module: cbfp_scale_ctrl

---
 rtl/cbfp_scale_ctrl.sv | 131 +++++++++++++
 tb/tb_cbfp_scale_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cbfp_scale_ctrl.sv
// rtl/cbfp_scale_ctrl.sv - CBFP block-minimum tracker with 2-entry shift-amount queue
module cbfp_scale_ctrl #(
  parameter int MAG_WIDTH   = 5,
  parameter int DATA_NUM    = 8,
  parameter int BLK_CYCLES  = 4,
  parameter int SHIFT_LIMIT = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [MAG_WIDTH-1:0] mag_in [0:DATA_NUM-1],
  input  logic                 flush,
  input  logic                 shift_ready,
  output logic                 shift_valid,
  output logic [MAG_WIDTH-1:0] shift_amt,
  output logic [7:0]           blk_cnt,
  output logic                 busy,
  output logic                 ovf_err
);

  localparam int                   CNT_W     = $clog2(BLK_CYCLES + 1);
  localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(BLK_CYCLES - 1);
  localparam logic [MAG_WIDTH-1:0] LIMIT     = MAG_WIDTH'(SHIFT_LIMIT);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state, next_state;
  logic [CNT_W-1:0]     beat_cnt;
  logic [MAG_WIDTH-1:0] run_min;
  logic [MAG_WIDTH-1:0] beat_min;
  logic [MAG_WIDTH-1:0] acc_min;
  logic [MAG_WIDTH-1:0] blk_min;
  logic                 blk_done;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic [MAG_WIDTH-1:0] q_mem [0:1];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           q_count;

  // Unsigned minimum across the lanes of the current beat
  always_comb begin
    beat_min = mag_in[0];
    for (int i = 1; i < DATA_NUM; i++) begin
      if (mag_in[i] < beat_min) beat_min = mag_in[i];
    end
  end

  // Fold the beat into the running minimum; a fresh block starts from the beat alone
  always_comb begin
    acc_min = beat_min;
    if (state == ACCUM && run_min < beat_min) acc_min = run_min;
    blk_min = (acc_min < LIMIT) ? acc_min : LIMIT;
  end

  // Next-state logic; flush wins over valid_in
  always_comb begin
    next_state = state;
    blk_done   = 1'b0;
    if (flush) begin
      next_state = IDLE;
    end else if (valid_in) begin
      case (state)
        IDLE:  next_state = ACCUM;
        ACCUM: begin
          if (beat_cnt == LAST_BEAT) begin
            next_state = IDLE;
            blk_done   = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Beat counter and running minimum; both restart whenever a block ends or is discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      run_min  <= '1;
    end else if (flush || (valid_in && blk_done)) begin
      beat_cnt <= '0;
      run_min  <= '1;
    end else if (valid_in) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
      run_min  <= acc_min;
    end
  end

  assign full = (q_count == 2'd2);
  assign pop  = shift_valid && shift_ready;
  assign push = blk_done && (!full || pop);

  // Output queue, completed-block counter and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_mem[0] <= '0;
      q_mem[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      q_count  <= 2'd0;
      blk_cnt  <= 8'd0;
      ovf_err  <= 1'b0;
    end else begin
      if (push) begin
        q_mem[wr_ptr] <= blk_min;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   q_count <= q_count + 2'd1;
        2'b01:   q_count <= q_count - 2'd1;
        default: q_count <= q_count;
      endcase
      if (blk_done) blk_cnt <= blk_cnt + 8'd1;
      if (blk_done && full && !pop) ovf_err <= 1'b1;
    end
  end

  assign shift_valid = (q_count != 2'd0);
  assign shift_amt   = shift_valid ? q_mem[rd_ptr] : '0;
  assign busy        = (state == ACCUM);

endmodule

// File: tb/tb_cbfp_scale_ctrl.sv
// tb/tb_cbfp_scale_ctrl.sv - self-checking bench for cbfp_scale_ctrl
module tb_cbfp_scale_ctrl;

  localparam int MW = 5;
  localparam int DN = 8;
  localparam int BC = 4;
  localparam int SL = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [MW-1:0] mag_in [0:DN-1];
  logic          flush;
  logic          shift_ready;
  logic          shift_valid;
  logic [MW-1:0] shift_amt;
  logic [7:0]    blk_cnt;
  logic          busy;
  logic          ovf_err;

  int total = 0;
  int bad   = 0;

  // Reference model: beats seen in the open block, its minimum, and the queue contents
  int m_beats;
  int m_min;
  int m_fifo[$];
  int m_blk;
  bit m_ovf;

  cbfp_scale_ctrl #(.MAG_WIDTH(MW), .DATA_NUM(DN), .BLK_CYCLES(BC), .SHIFT_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mag_in(mag_in), .flush(flush),
    .shift_ready(shift_ready), .shift_valid(shift_valid), .shift_amt(shift_amt),
    .blk_cnt(blk_cnt), .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " shift_valid"}, 32'(shift_valid), 32'(m_fifo.size() > 0));
    chk({tag, " shift_amt"},   32'(shift_amt),   (m_fifo.size() > 0) ? 32'(m_fifo[0]) : 32'd0);
    chk({tag, " blk_cnt"},     32'(blk_cnt),     32'(m_blk));
    chk({tag, " busy"},        32'(busy),        32'(m_beats > 0));
    chk({tag, " ovf_err"},     32'(ovf_err),     32'(m_ovf));
  endtask

  task automatic model_reset();
    m_beats = 0;
    m_min   = 0;
    m_fifo.delete();
    m_blk   = 0;
    m_ovf   = 1'b0;
  endtask

  // Fill a beat whose smallest lane equals mn
  task automatic set_beat(input int mn);
    for (int i = 0; i < DN; i++) mag_in[i] = MW'($urandom_range(31, mn));
    mag_in[$urandom_range(DN - 1, 0)] = MW'(mn);
  endtask

  // One clock: drive at negedge, update model at the edge, check at the next negedge
  task automatic cycle(input bit v, input bit fl, input bit rdy, input string tag);
    int bm;
    bit pop;
    valid_in    = v;
    flush       = fl;
    shift_ready = rdy;
    bm = 1 << MW;
    for (int i = 0; i < DN; i++) if (int'(mag_in[i]) < bm) bm = int'(mag_in[i]);
    @(posedge clk);
    pop = (m_fifo.size() > 0) && rdy;
    if (pop) void'(m_fifo.pop_front());
    if (fl) begin
      m_beats = 0;
    end else if (v) begin
      m_min = (m_beats == 0 || bm < m_min) ? bm : m_min;
      m_beats++;
      if (m_beats == BC) begin
        m_beats = 0;
        m_blk   = (m_blk + 1) % 256;
        if (m_fifo.size() < 2) m_fifo.push_back((m_min < SL) ? m_min : SL);
        else                   m_ovf = 1'b1;
      end
    end
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic beat(input int mn, input bit rdy, input string tag);
    set_beat(mn);
    cycle(1'b1, 1'b0, rdy, tag);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives
  task automatic do_reset(input string tag);
    valid_in = 1'b0;
    flush    = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk({tag, " rst shift_valid"}, 32'(shift_valid), 32'd0);
    chk({tag, " rst shift_amt"},   32'(shift_amt),   32'd0);
    chk({tag, " rst blk_cnt"},     32'(blk_cnt),     32'd0);
    chk({tag, " rst busy"},        32'(busy),        32'd0);
    chk({tag, " rst ovf_err"},     32'(ovf_err),     32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    valid_in    = 1'b0;
    flush       = 1'b0;
    shift_ready = 1'b0;
    for (int i = 0; i < DN; i++) mag_in[i] = '0;
    model_reset();
    #1;
    check_model("power-on");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic block: minima 9,7,11,8
    beat(9, 1, "b1"); beat(7, 1, "b2"); beat(11, 1, "b3"); beat(8, 1, "b4");
    chk("basic amt",   32'(shift_amt),   32'd7);
    chk("basic valid", 32'(shift_valid), 32'd1);
    chk("basic blk",   32'(blk_cnt),     32'd1);
    chk("basic busy",  32'(busy),        32'd0);
    cycle(0, 0, 1, "basic pop");

    // Clamp to SHIFT_LIMIT
    do_reset("clamp");
    for (int i = 0; i < BC; i++) begin
      for (int j = 0; j < DN; j++) mag_in[j] = MW'(15);
      cycle(1, 0, 1, "clamp beat");
    end
    chk("clamp amt", 32'(shift_amt), 32'd12);

    // Overflow: three blocks into a stalled 2-entry queue, with gaps inside blocks
    do_reset("ovf");
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < BC; i++) begin
        beat((i == 2) ? (b == 0 ? 3 : (b == 1 ? 5 : 6)) : 20, 0, "ovf beat");
        if (i == 1) cycle(0, 0, 0, "ovf gap");
      end
    end
    chk("ovf head", 32'(shift_amt), 32'd3);
    chk("ovf flag", 32'(ovf_err),   32'd1);
    chk("ovf blk",  32'(blk_cnt),   32'd3);
    cycle(0, 0, 1, "ovf pop1");
    chk("ovf second", 32'(shift_amt), 32'd5);
    cycle(0, 0, 1, "ovf pop2");
    chk("ovf empty", 32'(shift_valid), 32'd0);
    chk("ovf sticky", 32'(ovf_err), 32'd1);

    // Flush discards a partial block
    do_reset("flush");
    beat(1, 1, "fl p1"); beat(1, 1, "fl p2");
    cycle(1, 1, 1, "fl flush");
    chk("flush busy", 32'(busy), 32'd0);
    beat(10, 1, "fl b1"); beat(10, 1, "fl b2"); beat(4, 1, "fl b3"); beat(10, 1, "fl b4");
    chk("flush amt", 32'(shift_amt), 32'd4);
    chk("flush blk", 32'(blk_cnt),   32'd1);

    // Full queue with pop on the completing cycle: no overflow, new entry at tail
    do_reset("fullpop");
    for (int i = 0; i < BC; i++) beat(2, 0, "fp blkA");
    for (int i = 0; i < BC; i++) beat(3, 0, "fp blkB");
    for (int i = 0; i < BC - 1; i++) beat(4, 0, "fp blkC");
    beat(4, 1, "fp complete");
    chk("fullpop ovf",  32'(ovf_err),   32'd0);
    chk("fullpop head", 32'(shift_amt), 32'd3);
    cycle(0, 0, 1, "fp pop");
    chk("fullpop tail", 32'(shift_amt), 32'd4);

    // Reset mid-block with one entry queued
    do_reset("midrst pre");
    for (int i = 0; i < BC; i++) beat(6, 0, "mr blk");
    beat(8, 0, "mr p1"); beat(8, 0, "mr p2");
    chk("midrst queued", 32'(shift_valid), 32'd1);
    do_reset("midrst");
    for (int i = 0; i < BC; i++) beat(9, 0, "mr new");
    chk("midrst blk", 32'(blk_cnt),   32'd1);
    chk("midrst amt", 32'(shift_amt), 32'd9);
    cycle(0, 0, 1, "mr pop");
    chk("midrst single", 32'(shift_valid), 32'd0);

    // Randomized traffic against the model
    do_reset("rand");
    for (int n = 0; n < 400; n++) begin
      set_beat($urandom_range(31, 0));
      cycle($urandom_range(9, 0) < 7, $urandom_range(19, 0) == 0,
            $urandom_range(1, 0) == 1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
